life_gen_sched: RTL
===================

Name: life_gen_sched

Overview:
- Generation scheduler for the Game of Life cell store. It steps the next-generation engine row by row over a double-buffered, row-organised cell RAM.
- It shares the single RAM read port between VGA scanout (priority) and the engine, and swaps display and compute banks at the end of each generation.
- It sits between the button/switch front end, the VGA timing block and the cell RAM. It also supplies the generation count for the 7-seg display.

Parameters:
- GRID_W, 32, cells per row (one RAM word per row).
- GRID_H, 24, rows per bank.
- ROW_AW, 5, row address width; must satisfy 2^ROW_AW >= GRID_H.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; free-run enable.
- tick  in  1  one-cycle rate pulse from the speed divider.
- step  in  1  one-cycle single-generation request.
- clear  in  1  one-cycle request to zero both banks.
- vga_req  in  1  scanout row-read request.
- vga_row  in  ROW_AW  row requested by scanout.
- vga_ack  out  1  scanout data valid; asserted one cycle after a granted request.
- vga_data  out  GRID_W  row data for scanout.
- mem_rd_en  out  1  RAM read strobe.
- mem_rd_bank  out  1  bank selected for the read.
- mem_rd_addr  out  ROW_AW  row address for the read.
- mem_rd_data  in  GRID_W  read data; synchronous RAM with 1-cycle latency.
- mem_wr_en  out  1  RAM write strobe.
- mem_wr_bank  out  1  bank selected for the write.
- mem_wr_addr  out  ROW_AW  row address for the write.
- mem_wr_data  out  GRID_W  row data written.
- disp_bank  out  1  bank currently shown by scanout.
- busy  out  1  high whenever the FSM is not in IDLE.
- gen_done  out  1  one-cycle pulse when a generation completes.
- gen_count  out  16  generations completed since the last clear.

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0, including disp_bank = 0 and gen_count = 0.
  - RAM contents are untouched.
  - Reset mid-generation abandons the work. disp_bank keeps its reset value 0, so the displayed bank holds the last completed generation only if it was bank 0. This is accepted.
- Read-port arbitration (every cycle):
  - vga_req = 1: scanout is granted. mem_rd_en = 1, mem_rd_bank = disp_bank, mem_rd_addr = vga_row.
  - The next cycle, vga_ack = 1 and vga_data = mem_rd_data. vga_data holds its value otherwise.
  - A granted cycle stalls the engine: its pending read is not issued, and the FSM stays in its issue state.
  - Engine reads always use bank ~disp_bank... no: engine reads use bank disp_bank (the current generation). Engine writes use bank ~disp_bank.
- Start conditions, evaluated in IDLE only:
  - clear has priority.
  - Otherwise a generation starts on (run && tick) || step.
  - tick, step and clear arriving while busy are dropped, not queued.
- FSM states:
  - IDLE.
  - CLR: write zeros to row r of both banks, one bank per cycle, for 2*GRID_H cycles. Then gen_count = 0 and return to IDLE. No swap.
  - PA_RD / PA_CAP: prime "prev" with row GRID_H-1.
  - PB_RD / PB_CAP: prime "cur" with row 0.
  - NX_RD / NX_CAP: read row (r+1) mod GRID_H into "next". Row 0 is re-read when r = GRID_H-1 (vertical wrap).
  - WR:
    - mem_wr_en = 1, mem_wr_addr = r, mem_wr_data = rule(prev, cur, next).
    - Then shift: prev <= cur, cur <= next, r <= r+1.
    - Go to SWAP if r == GRID_H-1, else NX_RD.
  - SWAP: disp_bank toggles, gen_count += 1 (wraps 0xFFFF -> 0), gen_done pulses, then IDLE.
- Latency:
  - Capture states occur exactly one cycle after their read is issued.
  - With no contention a generation is 4 + 3*GRID_H + 1 cycles, i.e. 77 cycles at default size.
  - Each granted VGA cycle adds one cycle when it falls in an *_RD state.
  - A VGA grant during a capture, WR, CLR or SWAP cycle costs the engine nothing, because the engine is not using the read port then.
- Rule:
  - Cell c at row r counts its 8 neighbours: prev, cur, next rows at columns c-1, c, c+1 mod GRID_W (horizontal torus).
  - Born on exactly 3 neighbours; survives on 2 or 3; dies otherwise.
- busy = (state != IDLE).
- Outputs are registered, except mem_rd_* and mem_wr_*, which are combinational from state and the grant.

Decomposition:
- Header life_defs.vh: GRID_W/GRID_H defaults and the FSM state encodings (IDLE, CLR, PA_RD, PA_CAP, PB_RD, PB_CAP, NX_RD, NX_CAP, WR, SWAP).
- Sub-module life_row_rule: purely combinational. Inputs prev, cur, next [GRID_W-1:0]; output new row. It implements neighbour counting with horizontal wrap.

Test Plan:
- Blinker, single step: preload bank0 row5 = 0x00000070 (cols 4..6), other rows 0; pulse step.
  - busy high for exactly 77 cycles, gen_done once.
  - Bank1 rows 4, 5, 6 = 0x00000020; all other rows 0.
  - disp_bank = 1, gen_count = 1.
- Vertical + horizontal wrap: bank0 row 23 = 0x80000001, row 0 = 0x80000001 (2x2 block across the corner); step.
  - Bank1 rows 23 and 0 both = 0x80000001 (still life); rows 1..22 = 0.
- Scanout contention: hold vga_req = 1 for 10 cycles during NX_RD of row 3.
  - vga_ack follows each grant by 1 cycle with correct disp_bank data.
  - Generation takes 87 cycles.
  - Result is identical to the uncontended run.
- Drop while busy: run = 1, tick every 20 cycles.
  - Ticks during busy are ignored.
  - gen_count advances once per accepted tick.
  - A step during busy causes no extra generation.
- Clear: after 3 generations pulse clear.
  - 48 write cycles, alternating banks.
  - Both banks all 0, gen_count = 0, disp_bank unchanged.
- Reset mid-generation: assert rst at cycle 30 of a generation.
  - Next cycle: state IDLE, busy = 0, disp_bank = 0, gen_count = 0, no write strobes.

Source files
------------

// File: rtl/life_gen_sched_pkg.sv
// Shared definitions for the Game of Life generation scheduler: default grid
// geometry and the scheduler FSM state encoding.
package life_gen_sched_pkg;

  localparam int GRID_W_DEF = 32;  // cells per row, one RAM word per row
  localparam int GRID_H_DEF = 24;  // rows per bank
  localparam int ROW_AW_DEF = 5;   // row address width, 2**ROW_AW >= GRID_H

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CLR    = 4'd1,
    S_PA_RD  = 4'd2,
    S_PA_CAP = 4'd3,
    S_PB_RD  = 4'd4,
    S_PB_CAP = 4'd5,
    S_NX_RD  = 4'd6,
    S_NX_CAP = 4'd7,
    S_WR     = 4'd8,
    S_SWAP   = 4'd9
  } state_e;

endpackage

// File: rtl/life_gen_sched_if.sv
// Cell RAM port bundle: one synchronous read port (1-cycle latency) and one
// write port, each with a bank select. The scheduler is the master.
interface life_gen_sched_if #(
  parameter int GRID_W = 32,
  parameter int ROW_AW = 5
);

  logic              mem_rd_en;
  logic              mem_rd_bank;
  logic [ROW_AW-1:0] mem_rd_addr;
  logic [GRID_W-1:0] mem_rd_data;
  logic              mem_wr_en;
  logic              mem_wr_bank;
  logic [ROW_AW-1:0] mem_wr_addr;
  logic [GRID_W-1:0] mem_wr_data;

  modport master (
    output mem_rd_en, mem_rd_bank, mem_rd_addr,
    input  mem_rd_data,
    output mem_wr_en, mem_wr_bank, mem_wr_addr, mem_wr_data
  );

  modport slave (
    input  mem_rd_en, mem_rd_bank, mem_rd_addr,
    output mem_rd_data,
    input  mem_wr_en, mem_wr_bank, mem_wr_addr, mem_wr_data
  );

endinterface

// File: rtl/life_row_rule.sv
// Combinational next-generation rule for one row. Each cell counts its eight
// neighbours in the rows above/below and its own row, wrapping horizontally.
module life_row_rule
  import life_gen_sched_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF
) (
  input  logic [GRID_W-1:0] prev_i,
  input  logic [GRID_W-1:0] cur_i,
  input  logic [GRID_W-1:0] next_i,
  output logic [GRID_W-1:0] row_o
);

  for (genvar c = 0; c < GRID_W; c++) begin : g_cell
    localparam int L = (c + GRID_W - 1) % GRID_W;
    localparam int R = (c + 1) % GRID_W;
    logic [3:0] cnt;

    assign cnt = 4'(prev_i[L]) + 4'(prev_i[c]) + 4'(prev_i[R])
               + 4'(cur_i[L])                   + 4'(cur_i[R])
               + 4'(next_i[L]) + 4'(next_i[c]) + 4'(next_i[R]);

    // Born on exactly 3, survives on 2 or 3.
    assign row_o[c] = (cnt == 4'd3) || (cur_i[c] && (cnt == 4'd2));
  end

endmodule

// File: rtl/life_gen_sched.sv
// Generation scheduler: walks the compute engine row by row over the
// double-buffered cell RAM, lets VGA scanout pre-empt the shared read port,
// clears both banks on request and swaps banks when a generation completes.
module life_gen_sched
  import life_gen_sched_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF,
  parameter int ROW_AW = ROW_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              tick,
  input  logic              step,
  input  logic              clear,
  input  logic              vga_req,
  input  logic [ROW_AW-1:0] vga_row,
  output logic              vga_ack,
  output logic [GRID_W-1:0] vga_data,
  output logic              disp_bank,
  output logic              busy,
  output logic              gen_done,
  output logic [15:0]       gen_count,
  life_gen_sched_if.master  mem_if
);

  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(GRID_H - 1);
  localparam logic [ROW_AW-1:0] ROW_ONE  = ROW_AW'(1);

  state_e            state_q, state_d;
  logic [ROW_AW-1:0] row_q, row_d;
  logic              clr_bank_q, clr_bank_d;
  logic [GRID_W-1:0] prev_q, prev_d;
  logic [GRID_W-1:0] cur_q, cur_d;
  logic [GRID_W-1:0] nxt_q, nxt_d;
  logic              disp_q, disp_d;
  logic [15:0]       count_q, count_d;
  logic              done_d, done_q;
  logic              busy_q;
  logic              ack_q;
  logic [GRID_W-1:0] vga_hold_q;
  logic              grant;
  logic [GRID_W-1:0] new_row;

  // Scanout always wins the read port; nothing is granted while in reset.
  assign grant = vga_req && !rst;

  life_row_rule #(.GRID_W(GRID_W)) u_rule (
    .prev_i (prev_q),
    .cur_i  (cur_q),
    .next_i (nxt_q),
    .row_o  (new_row)
  );

  // Next-state decode plus the combinational RAM strobes.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    state_d    = state_q;
    row_d      = row_q;
    clr_bank_d = clr_bank_q;
    prev_d     = prev_q;
    cur_d      = cur_q;
    nxt_d      = nxt_q;
    disp_d     = disp_q;
    count_d    = count_q;
    done_d     = 1'b0;

    mem_if.mem_rd_en   = grant;
    mem_if.mem_rd_bank = disp_q;
    mem_if.mem_rd_addr = vga_row;
    mem_if.mem_wr_en   = 1'b0;
    mem_if.mem_wr_bank = ~disp_q;
    mem_if.mem_wr_addr = row_q;
    mem_if.mem_wr_data = '0;

    case (state_q)
      S_IDLE: begin
        if (clear) begin
          state_d    = S_CLR;
          row_d      = '0;
          clr_bank_d = 1'b0;
        end else if ((run && tick) || step) begin
          state_d = S_PA_RD;
        end
      end
      S_CLR: begin
        mem_if.mem_wr_en   = 1'b1;
        mem_if.mem_wr_bank = clr_bank_q;
        clr_bank_d         = ~clr_bank_q;
        if (clr_bank_q) begin
          if (row_q == LAST_ROW) begin
            state_d = S_IDLE;
            count_d = '0;
          end else begin
            row_d = row_q + ROW_ONE;
          end
        end
      end
      S_PA_RD: begin
        if (!grant) begin
          mem_if.mem_rd_en   = 1'b1;
          mem_if.mem_rd_addr = LAST_ROW;
          state_d            = S_PA_CAP;
        end
      end
      S_PA_CAP: begin
        prev_d  = mem_if.mem_rd_data;
        state_d = S_PB_RD;
      end
      S_PB_RD: begin
        if (!grant) begin
          mem_if.mem_rd_en   = 1'b1;
          mem_if.mem_rd_addr = '0;
          state_d            = S_PB_CAP;
        end
      end
      S_PB_CAP: begin
        cur_d   = mem_if.mem_rd_data;
        row_d   = '0;
        state_d = S_NX_RD;
      end
      S_NX_RD: begin
        if (!grant) begin
          mem_if.mem_rd_en   = 1'b1;
          mem_if.mem_rd_addr = (row_q == LAST_ROW) ? '0 : row_q + ROW_ONE;
          state_d            = S_NX_CAP;
        end
      end
      S_NX_CAP: begin
        nxt_d   = mem_if.mem_rd_data;
        state_d = S_WR;
      end
      S_WR: begin
        mem_if.mem_wr_en   = 1'b1;
        mem_if.mem_wr_data = new_row;
        prev_d             = cur_q;
        cur_d              = nxt_q;
        row_d              = row_q + ROW_ONE;
        state_d            = (row_q == LAST_ROW) ? S_SWAP : S_NX_RD;
      end
      S_SWAP: begin
        disp_d  = ~disp_q;
        count_d = count_q + 16'd1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Keep the RAM quiet while reset is held, even if the old state was mid-write.
    if (rst) begin
      mem_if.mem_wr_en = 1'b0;
    end
  end

  // Control state and registered status outputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      clr_bank_q <= 1'b0;
      disp_q     <= 1'b0;
      count_q    <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      clr_bank_q <= clr_bank_d;
      disp_q     <= disp_d;
      count_q    <= count_d;
      done_q     <= done_d;
      busy_q     <= (state_d != S_IDLE);
    end
  end

  // Three-row window into the current generation.
  always_ff @(posedge clk) begin
    // NOTE: no reset on the row window; each generation reloads all three rows before the rule uses them.
    prev_q <= prev_d;
    cur_q  <= cur_d;
    nxt_q  <= nxt_d;
  end

  // Scanout acknowledge one cycle after a grant; hold the last row in between.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q      <= 1'b0;
      vga_hold_q <= '0;
    end else begin
      ack_q <= grant;
      if (ack_q) begin
        vga_hold_q <= mem_if.mem_rd_data;
      end
    end
  end

  assign vga_ack   = ack_q;
  assign vga_data  = ack_q ? mem_if.mem_rd_data : vga_hold_q;
  assign disp_bank = disp_q;
  assign busy      = busy_q;
  assign gen_done  = done_q;
  assign gen_count = count_q;

endmodule
